pipelined_addsub: RTL and testbench
===================================

# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on input and output. It generalises the team's 16-bit combinational ripple adder: operand width and pipeline depth are configurable, and it adds a subtract mode, carry-in, and carry/overflow/zero flags. Each stage resolves a WIDTH/STAGES-bit slice and registers the slice carry, so throughput is one result per clock at any width. It sits between operand producers and result consumers in the datapath, and it can stall on downstream backpressure.

## Interface
- WIDTH, default 16: operand and result width in bits.
- STAGES, default 4: number of pipeline stages. WIDTH must be divisible by STAGES, and 1 ≤ STAGES ≤ WIDTH.
- clk  input  1  the single clock; rising-edge active.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  the operand beat is valid.
- in_ready  output  1  the block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in (borrow-in when subtracting).
- in_sub  input  1  mode: 0 = add, 1 = subtract.
- out_valid  output  1  the result beat is valid.
- out_ready  input  1  the consumer accepts the result this cycle.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out of the MSB.
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_sum == 0.

## Operation
- Arithmetic:
  - b' = in_sub ? ~in_b : in_b; c0 = in_cin ^ in_sub.
  - {out_cout, out_sum} = in_a + b' + c0, computed mod 2^(WIDTH+1).
  - Add with in_cin = 1 gives a+b+1. Subtract with in_cin = 0 gives a−b. Subtract with in_cin = 1 gives a−b−1.
  - In subtract mode, out_cout = 1 means no borrow.
- Flags:
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero is computed from the final out_sum.
- Slicing: let S = WIDTH/STAGES. Stage k (k = 0..STAGES−1) adds bits [k·S +: S] using the carry registered by stage k−1. Stage 0 uses c0.
- Operand skew: the upper operand slices, b' and the mode travel with the beat through skew registers until their stage is reached. Lower result slices are carried forward in registers until the final stage.
- Valid pipeline: each stage holds a valid bit. A bubble (valid = 0) advances exactly like data.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - When advance = 0, every stage register, including the valid bits, holds its value. The stall is global, and bubbles are not collapsed.
- While out_valid = 1 and out_ready = 0, all out_* signals stay stable.
- The behaviour of in_* signals when in_valid = 0 is don't-care. That data is never observable at the output.
- Reset (rst_n low, at any time):
  - All valid bits clear immediately.
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
  - in_ready = 1 as soon as out_valid = 0.
  - In-flight beats are discarded; there is no partial completion after reset release.

## Timing
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+STAGES−1 (STAGES cycles, counting the acceptance edge as the first stage load), provided no stall occurs in between.
- Every stall cycle (advance = 0) adds exactly one cycle of latency to every beat in flight.
- Throughput is 1 beat per cycle while out_ready = 1.
- in_ready is combinational from out_valid and out_ready. No other combinational path runs from input to output.
- Simultaneous accept and output handshake in the same cycle is legal. Both complete, and there is no loss or duplication.
- The critical path is one S-bit slice add plus the carry register. With STAGES = 1, the block is a registered full-width adder with latency 1.

## Test plan
Defaults WIDTH = 16, STAGES = 4.
- Carry wrap: add 0xFFFF + 0x0001, cin = 0. Required: after 4 cycles, out_sum = 0x0000, cout = 1, zero = 1, ovf = 0.
- Signed overflow: add 0x7FFF + 0x0001. Required: out_sum = 0x8000, ovf = 1, cout = 0. Also add 0x8000 + 0x8000. Required: out_sum = 0x0000, ovf = 1, cout = 1, zero = 1.
- Subtract and borrow:
  - sub 0x0005 − 0x0007, cin = 0. Required: out_sum = 0xFFFE, cout = 0.
  - sub 0x0007 − 0x0005, cin = 1. Required: out_sum = 0x0001, cout = 1.
  - sub 0x8000 − 0x0001. Required: out_sum = 0x7FFF, ovf = 1.
- Backpressure:
  - Stream 8 back-to-back beats while holding out_ready = 0 from cycle 6 to cycle 9.
  - Required: in_ready = 0 exactly while out_valid && !out_ready; outputs stay stable during the stall; all 8 results arrive in order with no loss or duplicate.
- Reset mid-operation:
  - Inject 3 beats, then pulse rst_n low for a half-cycle between edges.
  - Required: out_valid falls immediately and all outputs read 0; no stale result appears after reset release; the next beat returns after 4 cycles.
- Random regression:
  - Run 10,000 random beats with random in_valid and out_ready, for (WIDTH, STAGES) = (16, 4), (16, 1), (32, 8) and (8, 8).
  - Check every result against the reference model {cout, sum} = a + b' + c0, checking ovf and zero as well, and check ordering.

Source files
------------

// File: rtl/pipelined_addsub.sv
// ----------------------------------------------------------------------------
// pipelined_addsub: sliced, pipelined add/sub with valid/ready and flags.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic              advance;
  logic [STAGES-1:0] valid_q, valid_d, carry_q, carry_d;
  logic [STAGES-1:0] v_in, c_in, c_slice;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  sum_in [STAGES];
  logic [WIDTH-1:0]  sum_nxt [STAGES];
  logic              ovf_q, ovf_d, zero_q, zero_d;

  // Global stall: every stage, bubbles included, moves only when the output slot frees up.
  assign advance  = !valid_q[LAST] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE:0] slice_w;

    if (k == 0) begin : g_first
      assign a_in[k]   = in_a;
      assign b_in[k]   = in_sub ? ~in_b : in_b;
      assign sum_in[k] = '0;
      assign c_in[k]   = in_cin ^ in_sub;
      assign v_in[k]   = in_valid;
    end else begin : g_next
      assign a_in[k]   = a_q[k-1];
      assign b_in[k]   = b_q[k-1];
      assign sum_in[k] = sum_q[k-1];
      assign c_in[k]   = carry_q[k-1];
      assign v_in[k]   = valid_q[k-1];
    end

    assign slice_w    = {1'b0, a_in[k][k*SLICE +: SLICE]}
                      + {1'b0, b_in[k][k*SLICE +: SLICE]}
                      + (SLICE+1)'(c_in[k]);
    assign c_slice[k] = slice_w[SLICE];
    // Slices above k are still zero in sum_in, so OR-ing places this slice.
    assign sum_nxt[k] = sum_in[k] | (WIDTH'(slice_w[SLICE-1:0]) << (k*SLICE));
  end

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
      if (advance) begin
        valid_d[k] = v_in[k];
        carry_d[k] = c_slice[k];
        a_d[k]     = a_in[k];
        b_d[k]     = b_in[k];
        sum_d[k]   = sum_nxt[k];
      end
    end
    // Same-sign operands with a differing result sign is carry-in(MSB) ^ carry-out(MSB).
    if (advance) begin
      ovf_d  = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
               (sum_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
      zero_d = (sum_nxt[LAST] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = carry_q[LAST];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub: directed corner cases, backpressure, reset and
// random regression over four (WIDTH, STAGES) configurations.
`timescale 1ns/1ps
`default_nettype none

module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  iv, cin_v, sub_v, ordy;
  logic [31:0] a_v [4];
  logic [31:0] b_v [4];
  wire  [3:0]  ir, ov, co, of, zr;
  wire  [15:0] s0, s1;
  wire  [31:0] s2;
  wire  [7:0]  s3;
  int          total = 0;
  int          bad = 0;

  localparam int N_RAND = 10000;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_dut16x4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(a_v[0][15:0]), .in_b(b_v[0][15:0]), .in_cin(cin_v[0]), .in_sub(sub_v[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s0), .out_cout(co[0]),
    .out_ovf(of[0]), .out_zero(zr[0]));

  pipelined_addsub #(.WIDTH(16), .STAGES(1)) u_dut16x1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(a_v[1][15:0]), .in_b(b_v[1][15:0]), .in_cin(cin_v[1]), .in_sub(sub_v[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s1), .out_cout(co[1]),
    .out_ovf(of[1]), .out_zero(zr[1]));

  pipelined_addsub #(.WIDTH(32), .STAGES(8)) u_dut32x8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(a_v[2]), .in_b(b_v[2]), .in_cin(cin_v[2]), .in_sub(sub_v[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s2), .out_cout(co[2]),
    .out_ovf(of[2]), .out_zero(zr[2]));

  pipelined_addsub #(.WIDTH(8), .STAGES(8)) u_dut8x8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_a(a_v[3][7:0]), .in_b(b_v[3][7:0]), .in_cin(cin_v[3]), .in_sub(sub_v[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_sum(s3), .out_cout(co[3]),
    .out_ovf(of[3]), .out_zero(zr[3]));

  function automatic int width_of(int i);
    case (i)
      0, 1:    return 16;
      2:       return 32;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] sum_of(int i);
    case (i)
      0:       return 32'(s0);
      1:       return 32'(s1);
      2:       return s2;
      default: return 32'(s3);
    endcase
  endfunction

  function automatic logic [31:0] mask_of(int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return m[31:0];
  endfunction

  // Reference: integer arithmetic for {cout,sum}; overflow from true signed range.
  function automatic logic [34:0] model(int w, logic [31:0] a, logic [31:0] b,
                                        logic cin, logic sub);
    longint mask, av, bv, c0, tot, lim, sa, sb, st, sumv;
    logic   cout, ovf;
    mask = (longint'(1) << w) - 1;
    av   = longint'(a) & mask;
    bv   = sub ? (~longint'(b)) & mask : longint'(b) & mask;
    c0   = longint'(cin ^ sub);
    tot  = av + bv + c0;
    sumv = tot & mask;
    cout = ((tot >> w) & 1) != 0;
    lim  = longint'(1) << (w - 1);
    sa   = (av >= lim) ? av - (lim << 1) : av;
    sb   = (bv >= lim) ? bv - (lim << 1) : bv;
    st   = sa + sb + c0;
    ovf  = (st >= lim) || (st < -lim);
    return {cout, ovf, (sumv == 0), sumv[31:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({ov[i], co[i], of[i], zr[i], ir[i]} !== 5'b00001 || sum_of(i) !== 32'd0) begin
        bad++;
        $display("FAIL reset dut%0d: got v/c/o/z/r=%b sum=%h, want 00001 sum=0",
                 i, {ov[i], co[i], of[i], zr[i], ir[i]}, sum_of(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Vectors from the corner-case list, expected {cout,ovf,zero,sum} computed by hand.
  logic [15:0] ta [7] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007, 16'h8000, 16'h1234};
  logic [15:0] tb [7] = '{16'h0001, 16'h0001, 16'h8000, 16'h0007, 16'h0005, 16'h0001, 16'h1111};
  logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [18:0] te [7] = '{{3'b101, 16'h0000}, {3'b010, 16'h8000}, {3'b111, 16'h0000},
                          {3'b000, 16'hFFFE}, {3'b100, 16'h0001}, {3'b110, 16'h7FFF},
                          {3'b000, 16'h2346}};

  task automatic test_directed();
    int lat;
    for (int v = 0; v < 7; v++) begin
      @(posedge clk);
      #1;
      iv[0] = 1'b1; a_v[0] = 32'(ta[v]); b_v[0] = 32'(tb[v]);
      cin_v[0] = tc[v]; sub_v[0] = ts[v]; ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      lat = 1;
      while (ov[0] !== 1'b1 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      total++;
      if (lat !== 4) begin
        bad++;
        $display("FAIL latency vec%0d: got %0d cycles, want 4", v, lat);
      end
      total++;
      if ({co[0], of[0], zr[0], s0} !== te[v]) begin
        bad++;
        $display("FAIL directed vec%0d: got c/o/z=%b sum=%h, want c/o/z=%b sum=%h",
                 v, {co[0], of[0], zr[0]}, s0, te[v][18:16], te[v][15:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] q [$];
    logic [34:0] exp_v;
    logic [34:0] obs;
    int          sent = 0;
    int          rcvd = 0;
    bit          win;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      win      = (c >= 6 && c <= 9);
      iv[0]    = (sent < 8);
      a_v[0]   = 32'($urandom_range(16'hFFFF));
      b_v[0]   = 32'($urandom_range(16'hFFFF));
      cin_v[0] = 1'($urandom_range(1));
      sub_v[0] = 1'($urandom_range(1));
      ordy[0]  = !win;
      @(negedge clk);
      obs = {co[0], of[0], zr[0], sum_of(0)};
      total++;
      if (ir[0] !== !win) begin
        bad++;
        $display("FAIL bp_in_ready cycle%0d: got %b want %b", c, ir[0], !win);
      end
      if (win) begin
        total++;
        if (ov[0] !== 1'b1 || q.size() == 0 || obs !== q[0]) begin
          bad++;
          $display("FAIL bp_hold cycle%0d: got v=%b %h want v=1 %h",
                   c, ov[0], obs, (q.size() != 0) ? q[0] : 35'h0);
        end
      end
      if (ov[0] && ordy[0]) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL bp_extra cycle%0d: got %h want no result", c, obs);
        end else begin
          exp_v = q.pop_front();
          if (obs !== exp_v) begin
            bad++;
            $display("FAIL bp_data beat%0d: got %h want %h", rcvd, obs, exp_v);
          end
        end
        rcvd++;
      end
      if (iv[0] && ir[0]) begin
        q.push_back(model(16, a_v[0], b_v[0], cin_v[0], sub_v[0]));
        sent++;
      end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    total++;
    if (rcvd !== 8 || q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got %0d results (%0d pending) want 8 (0 pending)",
               rcvd, q.size());
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [34:0] exp_v;
    ordy[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      iv[0] = 1'b1; a_v[0] = 32'($urandom_range(16'hFFFF));
      b_v[0] = 32'($urandom_range(16'hFFFF)); cin_v[0] = 1'b0; sub_v[0] = 1'b0;
    end
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (ov[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: got out_valid=%b want 1", ov[0]);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ov[0], co[0], of[0], zr[0], ir[0], s0} !== {5'b00001, 16'h0000}) begin
      bad++;
      $display("FAIL rst_async: got v/c/o/z/r=%b sum=%h want 00001 sum=0000",
               {ov[0], co[0], of[0], zr[0], ir[0]}, s0);
    end
    #2;
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      total++;
      if (ov[0] !== 1'b0) begin
        bad++;
        $display("FAIL rst_stale cycle%0d: got out_valid=%b want 0", j, ov[0]);
      end
    end
    iv[0] = 1'b1; a_v[0] = 32'h0000_4321; b_v[0] = 32'h0000_1234;
    cin_v[0] = 1'b0; sub_v[0] = 1'b1;
    exp_v = model(16, a_v[0], b_v[0], 1'b0, 1'b1);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    lat = 1;
    while (ov[0] !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== 4 || {co[0], of[0], zr[0], sum_of(0)} !== exp_v) begin
      bad++;
      $display("FAIL rst_next: got lat=%0d %h want lat=4 %h",
               lat, {co[0], of[0], zr[0], sum_of(0)}, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [34:0] mem [4][64];
    logic [34:0] obs;
    int          wp [4];
    int          rp [4];
    int          sent [4];
    int          rcvd [4];
    int          cyc = 0;
    int          extra = 0;
    bit          done = 1'b0;
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      wp[i] = 0; rp[i] = 0; sent[i] = 0; rcvd[i] = 0;
    end
    while (!done && cyc < 60000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        m        = mask_of(width_of(i));
        iv[i]    = (sent[i] < N_RAND) && ($urandom_range(3) != 0);
        a_v[i]   = $urandom & m;
        b_v[i]   = $urandom & m;
        cin_v[i] = 1'($urandom_range(1));
        sub_v[i] = 1'($urandom_range(1));
        ordy[i]  = ($urandom_range(3) != 0);
      end
      @(negedge clk);
      done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (ov[i] && ordy[i]) begin
          obs = {co[i], of[i], zr[i], sum_of(i)};
          total++;
          if (wp[i] == rp[i]) begin
            bad++;
            $display("FAIL rand_extra dut%0d: got %h want no result", i, obs);
          end else begin
            if (obs !== mem[i][rp[i] % 64]) begin
              bad++;
              $display("FAIL rand dut%0d beat%0d: got %h want %h",
                       i, rcvd[i], obs, mem[i][rp[i] % 64]);
            end
            rp[i]++;
          end
          rcvd[i]++;
        end
        if (iv[i] && ir[i]) begin
          mem[i][wp[i] % 64] = model(width_of(i), a_v[i], b_v[i], cin_v[i], sub_v[i]);
          wp[i]++;
          sent[i]++;
        end
        if (rcvd[i] < N_RAND) done = 1'b0;
      end
      cyc++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL rand_timeout: got %0d/%0d/%0d/%0d results want %0d each",
               rcvd[0], rcvd[1], rcvd[2], rcvd[3], N_RAND);
    end
    iv = '0;
    ordy = '1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (ov[i]) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL rand_dup: got %0d extra results want 0", extra);
    end
  endtask

  initial begin
    iv = '0; cin_v = '0; sub_v = '0; ordy = '1;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
